if_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. It generates the PC, issues fetch requests on the SRAM-like instruction port, and delivers instructions to ID through the `fs_to_ds` valid/allowin handshake. It consumes the pipeline redirects produced at the other end of the pipe: exception and `eret` flushes from WB (`ws_ex`, `ws_eret`, `cp0_epc`) and branch redirects from ID. Fetch-side exceptions (AdEL on a misaligned PC) are tagged here and flow down to WB.

---
 rtl/if_stage_pkg.sv | 28 ++
 rtl/fs_inflight_ctr.sv | 51 +++++
 rtl/if_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, exception codes and bus layouts for the instruction-fetch stage.
package if_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 70;
  localparam int BR_BUS_WD       = 34;

  localparam logic [4:0]  EXCODE_ADEL  = 5'h04;
  localparam logic [31:0] EX_ENTRY_VEC = 32'hbfc00380;
  localparam logic [31:0] RESET_PC_VEC = 32'hbfc00000;

  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fs_inflight_ctr.sv
// Tracks fetch requests still owed a response and how many of those belong
// to a path that has since been flushed, so their data can be thrown away.
module fs_inflight_ctr (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic addr_ok_i,
  input  logic data_ok_i,
  input  logic stale_accept_i,
  output logic can_req_o,
  output logic drop_resp_o
);

  logic [1:0] out_q;
  logic [1:0] out_d;
  logic [1:0] discard_q;
  logic [1:0] discard_d;

  // A flush marks every request still owed after this cycle as garbage; a
  // request frozen across a flush and accepted later is garbage as well.
  always_comb begin
    out_d     = out_q + {1'b0, addr_ok_i} - {1'b0, data_ok_i};
    discard_d = discard_q;
    if (flush_i) begin
      discard_d = out_d;
    end else begin
      if (data_ok_i && (discard_q != 2'd0)) begin
        discard_d = discard_d - 2'd1;
      end
      if (stale_accept_i) begin
        discard_d = discard_d + 2'd1;
      end
    end
  end

  assign can_req_o   = (out_q == 2'd0) || ((out_q == 2'd1) && data_ok_i);
  assign drop_resp_o = (discard_q != 2'd0);

  // Counter state; only one request may ever be in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= 2'd0;
      discard_q <= 2'd0;
    end else begin
      assert (out_q != 2'd2);
      out_q     <= out_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, SRAM-like fetch port, one-entry
// instruction buffer, WB/branch redirects and AdEL tagging of misaligned PCs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_VEC,
  parameter logic [31:0] EX_ENTRY = EX_ENTRY_VEC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic                       ws_ex,
  input  logic                       ws_eret,
  input  logic [31:0]                cp0_epc,
  output logic                       inst_req,
  output logic                       inst_wr,
  output logic [1:0]                 inst_size,
  output logic [31:0]                inst_addr,
  output logic [31:0]                inst_wdata,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [31:0]                inst_rdata
);

  br_bus_t   br;
  fs_to_ds_t fs_bus;

  logic [31:0] pc_q, pc_d;
  logic        hold_q, hold_d;
  logic        stale_q, stale_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_target_q, redir_target_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        adel_q, adel_d;
  logic        halt_q, halt_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;

  logic        flush;
  logic [31:0] flush_target;
  logic        can_req;
  logic        drop_resp;
  logic        resp_ok;
  logic        slot_free;
  logic        issue_ok;
  logic        adel_start;
  logic        accept;
  logic        frozen;

  assign br           = br_bus;
  assign flush        = ws_ex || ws_eret;
  assign flush_target = ws_ex ? EX_ENTRY : cp0_epc;

  assign resp_ok        = inst_data_ok && !drop_resp && !flush;
  assign fs_to_ds_valid = !flush && (buf_valid_q || adel_q || resp_ok);
  assign slot_free      = !fs_to_ds_valid || ds_allowin;
  assign issue_ok       = !reset && !flush && can_req && slot_free && !br.stall
                          && !halt_q && !adel_q;

  assign inst_req   = !reset && (hold_q || (issue_ok && !pc_misaligned(pc_q)));
  assign adel_start = issue_ok && !hold_q && pc_misaligned(pc_q);
  assign accept     = inst_req && inst_addr_ok;
  assign frozen     = inst_req && !inst_addr_ok;

  assign inst_addr  = pc_q;
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'd2;
  assign inst_wdata = 32'd0;

  fs_inflight_ctr u_inflight (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush),
    .addr_ok_i      (accept),
    .data_ok_i      (inst_data_ok),
    .stale_accept_i (stale_q && accept),
    .can_req_o      (can_req),
    .drop_resp_o    (drop_resp)
  );

  // Next fetch address: redirects arriving while a request is frozen are
  // parked in the redirect buffer and handed to the PC once it is accepted.
  always_comb begin
    pc_d           = pc_q;
    redir_valid_d  = redir_valid_q;
    redir_target_d = redir_target_q;
    if (frozen) begin
      if (flush) begin
        redir_valid_d  = 1'b1;
        redir_target_d = flush_target;
      end else if (br.taken && !redir_valid_q) begin
        redir_valid_d  = 1'b1;
        redir_target_d = br.target;
      end
    end else if (flush) begin
      pc_d          = flush_target;
      redir_valid_d = 1'b0;
    end else if (redir_valid_q) begin
      pc_d          = redir_target_q;
      redir_valid_d = 1'b0;
    end else if (br.taken) begin
      pc_d = br.target;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Request hold, stale-request marking, instruction buffer and AdEL/halt tracking.
  always_comb begin
    hold_d        = frozen;
    stale_d       = stale_q;
    buf_valid_d   = buf_valid_q;
    buf_inst_d    = buf_inst_q;
    adel_d        = adel_q;
    halt_d        = halt_q;
    inflight_pc_d = inflight_pc_q;
    if (accept) begin
      stale_d       = 1'b0;
      inflight_pc_d = pc_q;
    end else if (flush && frozen) begin
      stale_d = 1'b1;
    end
    if (flush) begin
      buf_valid_d = 1'b0;
      adel_d      = 1'b0;
      halt_d      = 1'b0;
    end else begin
      if (resp_ok && !ds_allowin) begin
        buf_valid_d = 1'b1;
        buf_inst_d  = inst_rdata;
      end else if (ds_allowin) begin
        buf_valid_d = 1'b0;
      end
      if (adel_q && ds_allowin) begin
        adel_d = 1'b0;
        halt_d = 1'b1;
      end else if (adel_start) begin
        adel_d = 1'b1;
      end
    end
  end

  // Outgoing bus: AdEL entries carry the faulting PC and a null instruction.
  always_comb begin
    fs_bus.ex     = adel_q;
    fs_bus.excode = adel_q ? EXCODE_ADEL : 5'h00;
    fs_bus.inst   = adel_q ? 32'd0 : (buf_valid_q ? buf_inst_q : inst_rdata);
    fs_bus.pc     = adel_q ? pc_q : inflight_pc_q;
  end

  assign fs_to_ds_bus = fs_bus;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      hold_q         <= 1'b0;
      stale_q        <= 1'b0;
      redir_valid_q  <= 1'b0;
      redir_target_q <= 32'd0;
      buf_valid_q    <= 1'b0;
      buf_inst_q     <= 32'd0;
      adel_q         <= 1'b0;
      halt_q         <= 1'b0;
      inflight_pc_q  <= 32'd0;
    end else begin
      pc_q           <= pc_d;
      hold_q         <= hold_d;
      stale_q        <= stale_d;
      redir_valid_q  <= redir_valid_d;
      redir_target_q <= redir_target_d;
      buf_valid_q    <= buf_valid_d;
      buf_inst_q     <= buf_inst_d;
      adel_q         <= adel_d;
      halt_q         <= halt_d;
      inflight_pc_q  <= inflight_pc_d;
    end
  end

endmodule
